wb_stage: RTL and testbench

//  MEM->WB pipeline register plus write-back logic for MiniMIPS32.

---
 rtl/wb_stage.sv | 99 +++++++++
 tb/tb_wb_stage.sv | 119 +++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MiniMIPS32 MEM->WB pipeline register, load alignment and HI/LO write-back
module wb_stage (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [4:0]  mem_wa,
    input  logic        mem_wreg,
    input  logic [31:0] mem_dreg,
    input  logic        mem_mreg,
    input  logic [3:0]  mem_dre,
    input  logic        mem_sign,
    input  logic        mem_whilo,
    input  logic [63:0] mem_hilo,
    input  logic [31:0] dm,
    output logic [4:0]  wb_wa,
    output logic        wb_we,
    output logic [31:0] wb_wd,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [4:0]  r_wa;
    logic        r_wreg;
    logic [31:0] r_dreg;
    logic        r_mreg;
    logic [3:0]  r_dre;
    logic        r_sign;
    logic        r_whilo;
    logic [63:0] r_hilo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] w_wd;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_wa    <= 5'd0;
            r_wreg  <= 1'b0;
            r_dreg  <= 32'd0;
            r_mreg  <= 1'b0;
            r_dre   <= 4'd0;
            r_sign  <= 1'b0;
            r_whilo <= 1'b0;
            r_hilo  <= 64'd0;
        end else if (flush) begin
            r_wa    <= 5'd0;
            r_wreg  <= 1'b0;
            r_dreg  <= 32'd0;
            r_mreg  <= 1'b0;
            r_dre   <= 4'd0;
            r_sign  <= 1'b0;
            r_whilo <= 1'b0;
            r_hilo  <= 64'd0;
        end else if (!stall) begin
            r_wa    <= mem_wa;
            r_wreg  <= mem_wreg;
            r_dreg  <= mem_dreg;
            r_mreg  <= mem_mreg;
            r_dre   <= mem_dre;
            r_sign  <= mem_sign;
            r_whilo <= mem_whilo;
            r_hilo  <= mem_hilo;
        end
    end

    // Commit happens at the edge ending the WB cycle; a stall simply rewrites the same value.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (r_whilo) begin
            r_hi <= r_hilo[63:32];
            r_lo <= r_hilo[31:0];
        end
    end

    always_comb begin
        w_wd = r_dreg;
        if (r_mreg) begin
            case (r_dre)
                4'b0001: w_wd = {{24{r_sign & dm[7]}},  dm[7:0]};
                4'b0010: w_wd = {{24{r_sign & dm[15]}}, dm[15:8]};
                4'b0100: w_wd = {{24{r_sign & dm[23]}}, dm[23:16]};
                4'b1000: w_wd = {{24{r_sign & dm[31]}}, dm[31:24]};
                4'b0011: w_wd = {{16{r_sign & dm[15]}}, dm[15:0]};
                4'b1100: w_wd = {{16{r_sign & dm[31]}}, dm[31:16]};
                4'b1111: w_wd = dm;
                default: w_wd = 32'h0;
            endcase
        end
    end

    assign wb_wa = r_wa;
    assign wb_we = r_wreg & (r_wa != 5'd0);
    assign wb_wd = w_wd;
    assign hi_o  = r_whilo ? r_hilo[63:32] : r_hi;
    assign lo_o  = r_whilo ? r_hilo[31:0]  : r_lo;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage with directed MEM-stage vectors
module tb_wb_stage;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst_n   = 1'b0;
    logic        stall       = 1'b0;
    logic        flush       = 1'b0;
    logic [4:0]  mem_wa      = '0;
    logic        mem_wreg    = 1'b0;
    logic [31:0] mem_dreg    = '0;
    logic        mem_mreg    = 1'b0;
    logic [3:0]  mem_dre     = '0;
    logic        mem_sign    = 1'b0;
    logic        mem_whilo   = 1'b0;
    logic [63:0] mem_hilo    = '0;
    logic [31:0] dm          = '0;
    logic [4:0]  wb_wa;
    logic        wb_we;
    logic [31:0] wb_wd;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    wb_stage dut (
        .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n), .stall(stall), .flush(flush),
        .mem_wa(mem_wa), .mem_wreg(mem_wreg), .mem_dreg(mem_dreg), .mem_mreg(mem_mreg),
        .mem_dre(mem_dre), .mem_sign(mem_sign), .mem_whilo(mem_whilo), .mem_hilo(mem_hilo),
        .dm(dm), .wb_wa(wb_wa), .wb_we(wb_we), .wb_wd(wb_wd), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    typedef struct {
        string       name;
        logic [4:0]  wa;
        logic        we;
        logic [31:0] wd;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [31:0] DMV = 32'h80FF_7F01;
    localparam logic [63:0] HL1 = 64'hAAAA_0001_BBBB_0002;
    localparam logic [63:0] HL2 = 64'h1234_5678_9ABC_DEF0;

    // Each step: after the edge, drive the dm word for the entry now in WB, the next MEM
    // inputs and controls, and queue what WB must show during this cycle.
    task automatic step(input string nm, input logic rst, input logic st, input logic fl,
                        input logic [4:0] wa, input logic wreg, input logic [31:0] dreg,
                        input logic mreg, input logic [3:0] dre, input logic sgn,
                        input logic whilo, input logic [63:0] hilo, input logic [31:0] dmv,
                        input logic [4:0] e_wa, input logic e_we, input logic [31:0] e_wd,
                        input logic [31:0] e_hi, input logic [31:0] e_lo);
        exp_t e;
        @(posedge cpu_clk_50M);
        #1;
        cpu_rst_n = rst; stall = st; flush = fl;
        mem_wa = wa; mem_wreg = wreg; mem_dreg = dreg; mem_mreg = mreg;
        mem_dre = dre; mem_sign = sgn; mem_whilo = whilo; mem_hilo = hilo; dm = dmv;
        e.name = nm; e.wa = e_wa; e.we = e_we; e.wd = e_wd; e.hi = e_hi; e.lo = e_lo;
        exp_q.push_back(e);
    endtask

    always @(negedge cpu_clk_50M) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (wb_wa !== e.wa || wb_we !== e.we || wb_wd !== e.wd || hi_o !== e.hi || lo_o !== e.lo) begin
                n_errors++;
                $display("FAIL %s: got wa=%0d we=%b wd=%h hi=%h lo=%h, expected wa=%0d we=%b wd=%h hi=%h lo=%h",
                         e.name, wb_wa, wb_we, wb_wd, hi_o, lo_o, e.wa, e.we, e.wd, e.hi, e.lo);
            end
        end
    end

    initial begin
        //   name         rst st fl wa  wr dreg          mr dre      sg wh hilo   dm    | e_wa e_we e_wd           e_hi           e_lo
        step("reset_a",    0, 0, 0, 5,  1, 32'h1234_5678, 0, 4'b0000, 0, 1, HL1,  '0,     0,  0, 32'h0,         32'h0,         32'h0);
        step("reset_b",    0, 0, 0, 5,  1, 32'h1234_5678, 0, 4'b0000, 0, 1, HL1,  '0,     0,  0, 32'h0,         32'h0,         32'h0);
        step("release",    1, 0, 0, 0,  0, 32'h0,         0, 4'b0000, 0, 0, '0,   '0,     0,  0, 32'h0,         32'h0,         32'h0);
        step("post_rst",   1, 0, 0, 5,  1, 32'h1234_5678, 0, 4'b0000, 0, 0, '0,   '0,     0,  0, 32'h0,         32'h0,         32'h0);
        step("alu",        1, 0, 0, 7,  1, 32'h0,         1, 4'b1000, 1, 0, '0,   '0,     5,  1, 32'h1234_5678, 32'h0,         32'h0);
        step("ld_b3_s",    1, 0, 0, 8,  1, 32'h0,         1, 4'b0100, 0, 0, '0,   DMV,    7,  1, 32'hFFFF_FF80, 32'h0,         32'h0);
        step("ld_b2_u",    1, 0, 0, 9,  1, 32'h0,         1, 4'b1100, 1, 0, '0,   DMV,    8,  1, 32'h0000_00FF, 32'h0,         32'h0);
        step("ld_h1_s",    1, 0, 0, 10, 1, 32'h0,         1, 4'b0101, 1, 0, '0,   DMV,    9,  1, 32'hFFFF_80FF, 32'h0,         32'h0);
        step("ld_bad",     1, 0, 0, 11, 1, 32'h0,         1, 4'b0011, 0, 0, '0,   DMV,    10, 1, 32'h0,         32'h0,         32'h0);
        step("ld_h0_u",    1, 0, 0, 12, 1, 32'h0,         1, 4'b1111, 0, 0, '0,   DMV,    11, 1, 32'h0000_7F01, 32'h0,         32'h0);
        step("ld_word",    1, 0, 0, 0,  1, 32'hDEAD_BEEF, 0, 4'b0000, 0, 0, '0,   DMV,    12, 1, 32'h80FF_7F01, 32'h0,         32'h0);
        step("zero_reg",   1, 0, 0, 3,  1, 32'hAAAA_5555, 0, 4'b0000, 0, 0, '0,   '0,     0,  0, 32'hDEAD_BEEF, 32'h0,         32'h0);
        step("cap_a",      1, 1, 0, 4,  1, 32'h1111_1111, 0, 4'b0000, 0, 0, '0,   '0,     3,  1, 32'hAAAA_5555, 32'h0,         32'h0);
        step("stall_1",    1, 1, 0, 13, 0, 32'h2222_2222, 1, 4'b1111, 1, 1, HL2,  '0,     3,  1, 32'hAAAA_5555, 32'h0,         32'h0);
        step("stall_2",    1, 1, 0, 14, 1, 32'h3333_3333, 0, 4'b0000, 0, 0, '0,   '0,     3,  1, 32'hAAAA_5555, 32'h0,         32'h0);
        step("stall_3",    1, 1, 1, 15, 1, 32'h4444_4444, 0, 4'b0000, 0, 0, '0,   '0,     3,  1, 32'hAAAA_5555, 32'h0,         32'h0);
        step("flush",      1, 0, 0, 0,  0, 32'h0,         0, 4'b0000, 0, 1, HL1,  '0,     0,  0, 32'h0,         32'h0,         32'h0);
        step("hilo_byp",   1, 0, 0, 0,  0, 32'h0,         0, 4'b0000, 0, 0, '0,   '0,     0,  0, 32'h0,         32'hAAAA_0001, 32'hBBBB_0002);
        step("hilo_reg",   1, 0, 0, 6,  1, 32'h5555_0000, 0, 4'b0000, 0, 1, HL2,  '0,     0,  0, 32'h0,         32'hAAAA_0001, 32'hBBBB_0002);
        step("hilo_pend",  0, 0, 0, 0,  0, 32'h0,         0, 4'b0000, 0, 0, '0,   '0,     0,  0, 32'h0,         32'h0,         32'h0);
        step("rst_mid",    1, 0, 0, 0,  0, 32'h0,         0, 4'b0000, 0, 0, '0,   '0,     0,  0, 32'h0,         32'h0,         32'h0);
        step("rst_after",  1, 0, 0, 0,  0, 32'h0,         0, 4'b0000, 0, 0, '0,   '0,     0,  0, 32'h0,         32'h0,         32'h0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge cpu_clk_50M);
        if (exp_q.size() > 0) begin
            n_errors++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
